// File: rtl/x_fifo_drain_if.sv
// Handshake bundle for x_fifo_drain: FIFO pop port on the read side,
// valid/ready flit stream toward the crossbar/egress on the other.
interface x_fifo_drain_if #(
   parameter int DW = 8
);
   logic          fifo_empty_n;
   logic [DW-1:0] fifo_q;
   logic          fifo_re;
   logic          o_vld;
   logic          o_rdy;
   logic [DW-1:0] o_data;

   // slave is the drain stage itself; master is the FIFO plus downstream consumer
   modport slave (
      input  fifo_empty_n, fifo_q, o_rdy,
      output fifo_re, o_vld, o_data
   );

   modport master (
      output fifo_empty_n, fifo_q, o_rdy,
      input  fifo_re, o_vld, o_data
   );
endinterface

// File: rtl/x_fifo_drain.sv
// Read-side drain stage: pops the switch FIFO into a 2-slot (main + skid) buffer
// and re-presents flits on a valid/ready stream, with sync flush and a saturating transfer counter.
module x_fifo_drain #(
   parameter int DW = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rstn,
   x_fifo_drain_if.slave bus,
   input  logic          flush,
   input  logic          cnt_clr,
   output logic [CW-1:0] xfer_cnt,
   output logic          busy
);

   typedef enum logic [1:0] {
      OCC_0   = 2'd0,
      OCC_1   = 2'd1,
      OCC_2   = 2'd2,
      OCC_BAD = 2'd3
   } occ_t;

   occ_t          occ;
   occ_t          occ_next;
   logic [DW-1:0] main_q;
   logic [DW-1:0] main_d;
   logic [DW-1:0] skid_q;
   logic [DW-1:0] skid_d;
   logic [CW-1:0] cnt_next;
   logic          push;
   logic          pop;
   logic          vld;

   // Pop decision uses only registered occupancy, so o_rdy never reaches fifo_re
   always_comb begin
      push = bus.fifo_empty_n & ~flush & (occ != OCC_2);
      vld  = (occ != OCC_0) & ~flush;
      pop  = vld & bus.o_rdy;
   end

   assign bus.fifo_re = push;
   assign bus.o_vld   = vld;
   assign bus.o_data  = main_q;
   assign busy        = (occ != OCC_0) | bus.fifo_empty_n;

   always_comb begin
      occ_next = occ;
      main_d   = main_q;
      skid_d   = skid_q;
      if (flush) begin
         occ_next = OCC_0;
      end else begin
         case (occ)
            OCC_0: begin
               if (push) begin
                  main_d   = bus.fifo_q;
                  occ_next = OCC_1;
               end
            end
            OCC_1: begin
               if (pop && push) begin
                  main_d = bus.fifo_q;
               end else if (pop) begin
                  occ_next = OCC_0;
               end else if (push) begin
                  skid_d   = bus.fifo_q;
                  occ_next = OCC_2;
               end
            end
            OCC_2: begin
               // Full: fifo_re is blocked, so only the skid-to-main shift can happen
               if (pop) begin
                  main_d   = skid_q;
                  occ_next = OCC_1;
               end
            end
            default: begin
               occ_next = OCC_0;
            end
         endcase
      end
   end

   always_comb begin
      cnt_next = xfer_cnt;
      if (cnt_clr) begin
         cnt_next = '0;
      end else if (pop && (xfer_cnt != {CW{1'b1}})) begin
         cnt_next = xfer_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         occ      <= OCC_0;
         main_q   <= '0;
         skid_q   <= '0;
         xfer_cnt <= '0;
      end else begin
         occ      <= occ_next;
         main_q   <= main_d;
         skid_q   <= skid_d;
         xfer_cnt <= cnt_next;
      end
   end

   occ_legal: assert property (@(posedge clk) disable iff (!rstn) occ != OCC_BAD);

endmodule
